// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: debounced pushbutton and periodic auto toggling of a registered 2:1 mux select
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_PERIOD     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic auto,
    output logic sel,
    output logic sel_chg,
    output logic busy
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(AUTO_PERIOD);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, WAIT_REL, REL_DB} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [PW-1:0] pcnt;
    logic          btn_m, btn_s, auto_m, auto_s;
    logic          btn_acc, auto_tc, tog;

    always_ff @(posedge clk)
        if (rst) {btn_m, btn_s, auto_m, auto_s} <= '0;
        else     {btn_m, btn_s, auto_m, auto_s} <= {btn, btn_m, auto, auto_m};

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        btn_acc   = 1'b0;
        case (state)
            IDLE: if (btn_s) begin
                state_nxt = PRESS_DB;
                dcnt_nxt  = '0;
            end
            PRESS_DB: if (!btn_s) begin
                state_nxt = IDLE;
                dcnt_nxt  = '0;
            end else if (dcnt == D_LAST) begin
                state_nxt = WAIT_REL;
                dcnt_nxt  = '0;
                btn_acc   = 1'b1;
            end else dcnt_nxt = dcnt + 1'b1;
            WAIT_REL: if (!btn_s) begin
                state_nxt = REL_DB;
                dcnt_nxt  = '0;
            end
            REL_DB: if (btn_s) begin
                state_nxt = WAIT_REL;
                dcnt_nxt  = '0;
            end else if (dcnt == D_LAST) begin
                state_nxt = IDLE;
                dcnt_nxt  = '0;
            end else dcnt_nxt = dcnt + 1'b1;
            default: begin
                state_nxt = IDLE;
                dcnt_nxt  = '0;
            end
        endcase
    end

    // a coincident button accept and auto terminal count merge into one toggle
    assign auto_tc = auto_s && (pcnt == P_LAST);
    assign tog     = btn_acc || auto_tc;

    always_ff @(posedge clk)
        if (rst) begin
            state   <= IDLE;
            dcnt    <= '0;
            pcnt    <= '0;
            sel     <= 1'b0;
            sel_chg <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            dcnt    <= dcnt_nxt;
            pcnt    <= (tog || !auto_s) ? '0 : pcnt + 1'b1;
            sel     <= sel ^ tog;
            sel_chg <= tog;
            busy    <= state != IDLE;
        end
endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb_mux_sel_ctrl: per-cycle vector table run against mux_sel_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8
module tb_mux_sel_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic auto = 1'b0;
  logic sel, sel_chg, busy;
  typedef struct {
    logic       r;
    logic       b;
    logic       a;
    logic [2:0] exp;
    int         seg;
  } vec_t;
  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;
  int   seg = 0;
  mux_sel_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .auto(auto),
    .sel(sel), .sel_chg(sel_chg), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic b, input logic a,
                     input logic s, input logic c, input logic y);
    tbl.push_back('{r, b, a, {s, c, y}, seg});
  endtask
  task automatic chk(input logic [2:0] exp, input int idx, input int sg);
    total++;
    if ({sel, sel_chg, busy} !== exp) begin
      bad++;
      $display("FAIL vec%0d seg%0d sel/chg/busy got=%b want=%b",
               idx, sg, {sel, sel_chg, busy}, exp);
    end
  endtask
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: bench did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    seg = 0;
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    seg = 1;
    for (int k = 0; k < 30; k++)
      add(0, k < 20, 0, k >= 6, k == 6, k >= 3 && k <= 26);
    seg = 2;
    add(1, 0, 0, 0, 0, 0);
    seg = 3;
    for (int k = 0; k < 14; k++)
      add(0, k < 3 || (k >= 5 && k < 8), 0, 0, 0,
          (k >= 3 && k <= 5) || (k >= 8 && k <= 10));
    seg = 4;
    for (int k = 0; k < 46; k++)
      add(0, k <= 9 || k == 12 || k == 13 || (k >= 24 && k <= 33), 0,
          k >= 6 && k <= 29, k == 6 || k == 30,
          (k >= 3 && k <= 20) || (k >= 27 && k <= 40));
    seg = 5;
    add(1, 0, 0, 0, 0, 0);
    seg = 6;
    for (int k = 0; k < 41; k++)
      add(0, 0, k <= 28, (k >= 9 && k <= 16) || k >= 25,
          k == 9 || k == 17 || k == 25, 0);
    seg = 7;
    add(1, 0, 0, 0, 0, 0);
    seg = 8;
    for (int k = 0; k < 21; k++)
      add(0, k >= 3 && k <= 12, 1, k >= 9 && k <= 16,
          k == 9 || k == 17, k >= 6 && k <= 19);
    seg = 9;
    add(1, 0, 0, 0, 0, 0);
    seg = 10;
    for (int k = 0; k < 34; k++)
      add(k == 24, k <= 9 || k >= 20, 0,
          (k >= 6 && k <= 23) || k >= 31, k == 6 || k == 31,
          (k >= 3 && k <= 16) || k == 23 || k >= 28);
    foreach (tbl[i]) begin
      rst  = tbl[i].r;
      btn  = tbl[i].b;
      auto = tbl[i].a;
      @(posedge clk);
      #1;
      chk(tbl[i].exp, i, tbl[i].seg);
    end
    rst  = 1'b1;
    btn  = 1'b1;
    auto = 1'b1;
    @(posedge clk);
    #1;
    chk(3'b000, tbl.size(), 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
